// File: rtl/stbus_rx_deframer.sv
// ST-BUS receive deframer: synchronises c4/f0/data into clk50, tracks frame alignment, emits channel bytes.
// Latency pin edge -> ch_valid is SYNC_STAGES+2 clk50 cycles; no backpressure, every completed byte is strobed once.
module stbus_rx_deframer #(
    parameter int CHANNELS    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int INT_WIDTH   = 8
) (
    input  logic                        clk50,
    input  logic                        reset_in_rg,
    input  logic                        c4,
    input  logic                        f0,
    input  logic                        data_from_dt,
    output logic [7:0]                  ch_data,
    output logic [$clog2(CHANNELS)-1:0] ch_num,
    output logic                        ch_valid,
    output logic                        frame_start,
    output logic                        frame_err,
    output logic                        locked,
    output logic                        cpu_int
);
    localparam int CNT_W = $clog2(CHANNELS * 16);
    localparam int CH_W  = $clog2(CHANNELS);
    localparam int IW    = (INT_WIDTH > 1) ? $clog2(INT_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHANNELS * 16 - 1);

    typedef enum logic {HUNT, LOCKED} state_t;

    logic [SYNC_STAGES-1:0] c4_sync;
    logic [SYNC_STAGES-1:0] f0_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   c4_prev;
    logic                   c4_s;
    logic                   f0_s;
    logic                   dat_s;
    logic                   c4_fall;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [7:0]             shreg;
    logic                   byte_done;
    logic [CH_W-1:0]        done_ch;
    logic                   sample;
    logic [IW-1:0]          int_cnt;

    assign c4_s    = c4_sync[SYNC_STAGES-1];
    assign f0_s    = f0_sync[SYNC_STAGES-1];
    assign dat_s   = dat_sync[SYNC_STAGES-1];
    assign c4_fall = c4_prev & ~c4_s;

    // Mid-cell sample; a misplaced f0 throws away the byte being assembled.
    assign sample = c4_fall && (state == LOCKED) && cnt[0]
                    && !(!f0_s && (cnt != CNT_LAST));

    always_ff @(posedge clk50 or posedge reset_in_rg) begin
        if (reset_in_rg) begin
            c4_sync  <= '0;
            f0_sync  <= '0;
            dat_sync <= '0;
            c4_prev  <= 1'b0;
        end else begin
            c4_sync  <= {c4_sync[SYNC_STAGES-2:0], c4};
            f0_sync  <= {f0_sync[SYNC_STAGES-2:0], f0};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], data_from_dt};
            c4_prev  <= c4_s;
        end
    end

    always_ff @(posedge clk50 or posedge reset_in_rg) begin
        if (reset_in_rg) begin
            state       <= HUNT;
            cnt         <= '0;
            shreg       <= '0;
            byte_done   <= 1'b0;
            done_ch     <= '0;
            frame_start <= 1'b0;
            frame_err   <= 1'b0;
            locked      <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_err   <= 1'b0;
            byte_done   <= 1'b0;
            if (sample) begin
                shreg     <= {shreg[6:0], dat_s};
                byte_done <= (cnt[3:1] == 3'd7);
                done_ch   <= cnt[CNT_W-1:4];
            end
            if (c4_fall) begin
                case (state)
                    HUNT: begin
                        if (!f0_s) begin
                            cnt         <= '0;
                            frame_start <= 1'b1;
                            state       <= LOCKED;
                            locked      <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (!f0_s) begin
                            frame_start <= 1'b1;
                            frame_err   <= (cnt != CNT_LAST);
                            cnt         <= '0;
                        end else if (cnt == CNT_LAST) begin
                            frame_err <= 1'b1;
                            state     <= HUNT;
                            locked    <= 1'b0;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk50 or posedge reset_in_rg) begin
        if (reset_in_rg) begin
            ch_valid <= 1'b0;
            ch_data  <= '0;
            ch_num   <= '0;
        end else begin
            ch_valid <= byte_done;
            if (byte_done) begin
                ch_data <= shreg;
                ch_num  <= done_ch;
            end
        end
    end

    // A retrigger while the pulse is still high restarts the width count.
    always_ff @(posedge clk50 or posedge reset_in_rg) begin
        if (reset_in_rg) begin
            cpu_int <= 1'b0;
            int_cnt <= '0;
        end else if (ch_valid && (ch_num == CH_W'(CHANNELS - 1))) begin
            cpu_int <= 1'b1;
            int_cnt <= IW'(INT_WIDTH - 1);
        end else if (int_cnt != '0) begin
            int_cnt <= int_cnt - 1'b1;
        end else begin
            cpu_int <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stbus_rx_deframer.sv
// Random-data bench for stbus_rx_deframer: a per-c4-fall protocol model predicts every output event.
module tb_stbus_rx_deframer;
    localparam int CHANNELS    = 32;
    localparam int SYNC_STAGES = 2;
    localparam int INT_WIDTH   = 8;
    localparam int LAST        = CHANNELS * 16 - 1;
    localparam int HALF        = 70;
    localparam int MAXF        = 6000;

    logic       clk50        = 1'b0;
    logic       reset_in_rg  = 1'b1;
    logic       c4           = 1'b1;
    logic       f0           = 1'b1;
    logic       data_from_dt = 1'b0;
    logic [7:0] ch_data;
    logic [$clog2(CHANNELS)-1:0] ch_num;
    logic       ch_valid, frame_start, frame_err, locked, cpu_int;

    stbus_rx_deframer #(
        .CHANNELS(CHANNELS), .SYNC_STAGES(SYNC_STAGES), .INT_WIDTH(INT_WIDTH)
    ) dut (
        .clk50(clk50), .reset_in_rg(reset_in_rg), .c4(c4), .f0(f0),
        .data_from_dt(data_from_dt), .ch_data(ch_data), .ch_num(ch_num),
        .ch_valid(ch_valid), .frame_start(frame_start), .frame_err(frame_err),
        .locked(locked), .cpu_int(cpu_int)
    );

    always #10 clk50 = ~clk50;

    int vectors     = 0;
    int miscompares = 0;

    function automatic void chk(string name, int got, int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // Expected events per c4 fall index, and what the DUT actually produced.
    bit exp_chv [MAXF];
    int exp_num [MAXF];
    int exp_dat [MAXF];
    bit exp_fs  [MAXF];
    bit exp_fe  [MAXF];
    bit exp_lk  [MAXF];
    bit seen_chv[MAXF];
    bit seen_fs [MAXF];
    bit seen_fe [MAXF];
    int fall_idx = 0;

    bit       m_locked = 1'b0;
    int       m_pos    = 0;
    bit [7:0] m_bits   = 8'h00;

    // Position m_pos counts falls since the last accepted f0; odd positions are bit-cell centres.
    function automatic void model_step(int k, bit f0v, bit dv);
        bit misplaced;
        misplaced = m_locked && !f0v && (m_pos != LAST);
        if (m_locked) begin
            if (!misplaced && (m_pos % 2 == 1)) begin
                m_bits = {m_bits[6:0], dv};
                if ((m_pos / 2) % 8 == 7) begin
                    exp_chv[k] = 1'b1;
                    exp_num[k] = m_pos / 16;
                    exp_dat[k] = int'(m_bits);
                end
            end
            if (!f0v) begin
                exp_fs[k] = 1'b1;
                exp_fe[k] = misplaced;
                m_pos     = 0;
            end else if (m_pos == LAST) begin
                exp_fe[k] = 1'b1;
                m_locked  = 1'b0;
                m_pos     = 0;
            end else begin
                m_pos++;
            end
        end else if (!f0v) begin
            exp_fs[k] = 1'b1;
            m_locked  = 1'b1;
            m_pos     = 0;
        end
        exp_lk[k] = m_locked;
    endfunction

    function automatic void close_fall(int k);
        chk("ch_valid_seen", seen_chv[k], exp_chv[k]);
        chk("frame_start_seen", seen_fs[k], exp_fs[k]);
        chk("frame_err_seen", seen_fe[k], exp_fe[k]);
    endfunction

    int   last_k = 0, since = 0, cint = 0;
    int   n_chv = 0, n_fs = 0, n_fe = 0, n_cpu = 0, cpu_w = 0, last_cpu_w = 0;
    logic cpu_prev = 1'b0;

    always @(negedge clk50) begin : compare
        int k;
        k = fall_idx;
        if (k != last_k) begin
            close_fall(last_k);
            last_k = k;
            since  = 0;
        end
        since++;
        if (reset_in_rg) begin
            chk("rst_ch_valid", ch_valid, 0);
            chk("rst_frame_start", frame_start, 0);
            chk("rst_frame_err", frame_err, 0);
            chk("rst_locked", locked, 0);
            chk("rst_cpu_int", cpu_int, 0);
            cint = 0;
        end else begin
            if (ch_valid) begin
                n_chv++;
                chk("ch_valid_expected", int'(exp_chv[k] && !seen_chv[k]), 1);
                seen_chv[k] = 1'b1;
                chk("ch_num", ch_num, exp_num[k]);
                chk("ch_data", ch_data, exp_dat[k]);
            end
            if (frame_start) begin
                n_fs++;
                chk("frame_start_expected", int'(exp_fs[k] && !seen_fs[k]), 1);
                seen_fs[k] = 1'b1;
            end
            if (frame_err) begin
                n_fe++;
                chk("frame_err_expected", int'(exp_fe[k] && !seen_fe[k]), 1);
                seen_fe[k] = 1'b1;
            end
            if (since == 5) chk("locked", locked, exp_lk[k]);
            chk("cpu_int", cpu_int, int'(cint > 0));
            if (cint > 0) cint--;
            if (ch_valid && exp_chv[k] && exp_num[k] == CHANNELS - 1) cint = INT_WIDTH;
        end
        if (cpu_int && !cpu_prev) begin
            n_cpu++;
            cpu_w = 0;
        end
        if (cpu_int) cpu_w++;
        else if (cpu_prev) last_cpu_w = cpu_w;
        cpu_prev = cpu_int;
    end

    task automatic drive_fall(input bit f0v, input bit dv);
        if (fall_idx >= MAXF - 1) begin
            $display("FAIL fall_budget: got %0d, expected below %0d", fall_idx, MAXF - 1);
            $fatal(1, "fall budget exhausted");
        end
        f0 = f0v;
        data_from_dt = dv;
        #(HALF);
        c4 = 1'b0;
        fall_idx++;
        model_step(fall_idx, f0v, dv);
        #(HALF);
        c4 = 1'b1;
    endtask

    // pat=1 puts byte A0+k in slot k; unsampled half-cells always carry random bits.
    task automatic send_frame(input int len, input int f0_pos, input bit pat);
        bit [7:0] b;
        bit       dv;
        for (int p = 0; p < len; p++) begin
            b  = 8'hA0 + 8'(p / 16);
            dv = (pat && (p % 2 == 1)) ? b[7 - ((p / 2) % 8)] : 1'($urandom);
            drive_fall(!(p == f0_pos), dv);
        end
    endtask

    task automatic idle_falls(input int n);
        for (int i = 0; i < n; i++) drive_fall(1'b1, 1'($urandom));
    endtask

    task automatic settle;
        #(4 * HALF);
    endtask

    int s_chv, s_fs, s_fe, s_cpu;
    task automatic snap;
        s_chv = n_chv; s_fs = n_fs; s_fe = n_fe; s_cpu = n_cpu;
    endtask

    initial begin
        #55;
        chk("reset_ch_data", ch_data, 0);
        chk("reset_ch_num", ch_num, 0);
        chk("reset_locked", locked, 0);
        reset_in_rg = 1'b0;
        @(posedge clk50);
        #3;

        // No f0 at all: stays in hunt.
        snap();
        idle_falls(1000);
        settle();
        chk("t2_ch_valid_count", n_chv - s_chv, 0);
        chk("t2_cpu_pulses", n_cpu - s_cpu, 0);
        chk("t2_locked", locked, 0);

        // Lock then three clean frames of A0..BF.
        snap();
        drive_fall(1'b0, 1'($urandom));
        for (int f = 0; f < 3; f++) send_frame(512, 511, 1'b1);
        settle();
        chk("t1_ch_valid_count", n_chv - s_chv, 96);
        chk("t1_frame_start_count", n_fs - s_fs, 4);
        chk("t1_frame_err_count", n_fe - s_fe, 0);
        chk("t1_cpu_pulses", n_cpu - s_cpu, 3);
        chk("t1_cpu_width", last_cpu_w, 8);
        chk("t1_last_byte", ch_data, 8'hBF);
        chk("t1_last_num", ch_num, 31);
        chk("t1_locked", locked, 1);

        // Early f0 at cnt=200, then a normal frame.
        snap();
        send_frame(201, 200, 1'b0);
        send_frame(512, 511, 1'b0);
        settle();
        chk("t3_ch_valid_count", n_chv - s_chv, 44);
        chk("t3_frame_start_count", n_fs - s_fs, 2);
        chk("t3_frame_err_count", n_fe - s_fe, 1);

        // f0 withheld for one frame, then relock.
        snap();
        send_frame(512, -1, 1'b0);
        settle();
        chk("t4_ch_valid_count", n_chv - s_chv, 32);
        chk("t4_frame_err_count", n_fe - s_fe, 1);
        chk("t4_frame_start_count", n_fs - s_fs, 0);
        chk("t4_locked", locked, 0);
        snap();
        drive_fall(1'b0, 1'($urandom));
        send_frame(512, 511, 1'b1);
        settle();
        chk("t4_relock_ch_valid_count", n_chv - s_chv, 32);
        chk("t4_relock_byte", ch_data, 8'hBF);
        chk("t4_relock_locked", locked, 1);

        // Reset during channel 5 bit 3.
        snap();
        send_frame(89, -1, 1'b0);
        chk("t6_pre_reset_count", n_chv - s_chv, 5);
        #5;
        reset_in_rg = 1'b1;
        m_locked = 1'b0;
        m_pos = 0;
        exp_lk[fall_idx] = 1'b0;
        #1;
        chk("t6_async_locked", locked, 0);
        chk("t6_async_ch_data", ch_data, 0);
        chk("t6_async_ch_num", ch_num, 0);
        chk("t6_async_ch_valid", ch_valid, 0);
        #19;
        reset_in_rg = 1'b0;
        #(2 * HALF - 25);
        snap();
        idle_falls(50);
        settle();
        chk("t6_post_reset_count", n_chv - s_chv, 0);
        chk("t6_post_reset_locked", locked, 0);
        snap();
        drive_fall(1'b0, 1'($urandom));
        send_frame(512, 511, 1'b1);
        settle();
        chk("t6_relock_ch_valid_count", n_chv - s_chv, 32);

        close_fall(fall_idx);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
